// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-based imem requests, instruction queue, redirect flush
module fetch_unit #(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned          QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] instr_pc4,
    output logic                  instr_valid,
    input  logic                  instr_ready
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] q_addr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] f_addr [QUEUE_DEPTH];
    logic [PW-1:0]         q_head, q_tail, f_head, f_tail;
    logic [CW-1:0]         q_count, outstanding, drop;
    logic [CW:0]           credit_sum;
    logic                  issue, live_resp, push, pop;

    // outstanding counts every pending response, including ones marked for drop,
    // so the in-flight address FIFO only ever holds live requests.
    assign credit_sum  = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req    = !rst && !redirect && (credit_sum < (CW+1)'(QUEUE_DEPTH));
    assign imem_addr   = pc;
    assign issue       = imem_req && imem_ready;
    assign live_resp   = imem_rvalid && (drop == '0);
    assign push        = live_resp && !redirect;
    assign instr_valid = !rst && (q_count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;

    assign instr     = instr_valid ? q_data[q_head] : NOP;
    assign instr_pc  = instr_valid ? q_addr[q_head] : '0;
    assign instr_pc4 = instr_valid ? q_addr[q_head] + DATA_WIDTH'(4) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            f_head      <= '0;
            f_tail      <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            // Everything still pending becomes a drop; a response landing now is already consumed.
            pc          <= redirect_pc & ~DATA_WIDTH'(3);
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            f_head      <= '0;
            f_tail      <= '0;
            outstanding <= outstanding - CW'(imem_rvalid);
            drop        <= outstanding - CW'(imem_rvalid);
        end else begin
            if (issue) begin
                pc     <= pc + DATA_WIDTH'(4);
                f_tail <= f_tail + 1'b1;
            end
            if (live_resp) f_head <= f_head + 1'b1;
            if (push)      q_tail <= q_tail + 1'b1;
            if (pop)       q_head <= q_head + 1'b1;
            q_count     <= q_count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (imem_rvalid && drop != '0) drop <= drop - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect) begin
            if (issue) f_addr[f_tail] <= pc;
            if (push) begin
                q_addr[q_tail] <= f_addr[f_head];
                q_data[q_tail] <= imem_rdata;
            end
        end
    end

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed testbench for fetch_unit with a fixed-latency instruction memory model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr, instr_pc, instr_pc4;
    logic        instr_valid, instr_ready = 1'b1;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t       pend[$];
    logic [31:0] acc_q[$], cons_pc[$], cons_ins[$], cons_pc4[$];
    int          lat = 1;
    logic        mem_rdy = 1'b1;
    int          cyc = 0;
    logic        s_acc, s_rv;
    logic [31:0] s_addr;
    int          tests = 0, fails = 0;
    int          n0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive memory for this cycle, let logic settle, and log handshakes.
    task automatic settle();
        imem_ready = mem_rdy;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        s_acc  = imem_req && imem_ready;
        s_addr = imem_addr;
        s_rv   = imem_rvalid;
        if (s_acc) acc_q.push_back(s_addr);
        if (!rst && !redirect && instr_valid && instr_ready) begin
            cons_pc.push_back(instr_pc);
            cons_ins.push_back(instr);
            cons_pc4.push_back(instr_pc4);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) pend.delete();
        else begin
            if (s_rv) void'(pend.pop_front());
            if (s_acc) pend.push_back('{due: cyc + lat, addr: s_addr});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic clear_log();
        acc_q.delete(); cons_pc.delete(); cons_ins.delete(); cons_pc4.delete();
    endtask

    initial begin
        // Reset state and first fetches with a 1-cycle memory.
        rst = 1'b1; lat = 1; instr_ready = 1'b1;
        step(1);
        settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_pc4", instr_pc4, 32'd0);
        advance();
        rst = 1'b0; clear_log();
        settle();
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        advance();
        settle();
        chk("c1_valid", 32'(instr_valid), 32'd0);
        chk("c1_addr", imem_addr, 32'h4);
        advance();
        settle();
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_pc", instr_pc, 32'h0);
        chk("c2_pc4", instr_pc4, 32'h4);
        chk("c2_instr", instr, mem_data(32'h0));
        advance();
        step(12);
        chk("run_count", 32'(cons_pc.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("run_pc", cons_pc[i], 32'(4 * i));
            chk("run_pc4", cons_pc4[i], 32'(4 * i + 4));
            chk("run_instr", cons_ins[i], mem_data(32'(4 * i)));
        end

        // Decode stalled for 10 cycles: only QUEUE_DEPTH requests go out.
        rst = 1'b1; step(1); rst = 1'b0; clear_log();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (i >= 3) begin
                chk("stall_valid", 32'(instr_valid), 32'd1);
                chk("stall_pc", instr_pc, 32'h0);
                chk("stall_instr", instr, mem_data(32'h0));
            end
            advance();
        end
        chk("stall_issued", 32'(acc_q.size()), 32'd2);
        instr_ready = 1'b1;
        step(15);
        chk("drain_count", 32'(cons_pc.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) chk("drain_pc", cons_pc[i], 32'(4 * i));

        // Redirect with two responses outstanding on a 3-cycle memory.
        rst = 1'b1; lat = 3; step(1); rst = 1'b0; clear_log();
        step(2);
        chk("redir_outstanding", 32'(acc_q.size()), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        settle();
        chk("redir_req_low", 32'(imem_req), 32'd0);
        advance();
        redirect = 1'b0;
        step(25);
        chk("redir_acc2", acc_q[2], 32'h100);
        chk("redir_count", 32'(cons_pc.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("redir_pc", cons_pc[i], 32'h100 + 32'(4 * i));
            chk("redir_instr", cons_ins[i], mem_data(32'h100 + 32'(4 * i)));
        end

        // Memory not ready for 5 cycles: request held, PC frozen, queue drains.
        rst = 1'b1; lat = 1; step(1); rst = 1'b0; clear_log();
        step(6);
        mem_rdy = 1'b0;
        n0 = acc_q.size();
        step(4);
        settle();
        chk("mstall_req", 32'(imem_req), 32'd1);
        chk("mstall_addr", imem_addr, 32'(4 * n0));
        chk("mstall_valid", 32'(instr_valid), 32'd0);
        chk("mstall_instr", instr, 32'h0000_0013);
        chk("mstall_noacc", 32'(acc_q.size()), 32'(n0));
        advance();
        mem_rdy = 1'b1;
        step(2);
        chk("mstall_resume", acc_q[n0], 32'(4 * n0));

        // Reset mid-stream with a full queue.
        rst = 1'b1; step(1); rst = 1'b0; clear_log();
        instr_ready = 1'b0;
        step(5);
        settle();
        chk("full_valid", 32'(instr_valid), 32'd1);
        advance();
        rst = 1'b1;
        settle();
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_req", 32'(imem_req), 32'd0);
        chk("mrst_instr", instr, 32'h0000_0013);
        advance();
        rst = 1'b0; instr_ready = 1'b1;
        settle();
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_req_after", 32'(imem_req), 32'd1);
        chk("mrst_valid_after", 32'(instr_valid), 32'd0);
        advance();

        // PC wrap at the top of the address space.
        step(4);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        settle();
        advance();
        redirect = 1'b0; clear_log();
        step(12);
        chk("wrap_acc_count", 32'(acc_q.size() >= 2), 32'd1);
        chk("wrap_acc0", acc_q[0], 32'hFFFF_FFFC);
        chk("wrap_acc1", acc_q[1], 32'h0000_0000);
        chk("wrap_cons_count", 32'(cons_pc.size() >= 2), 32'd1);
        chk("wrap_pc0", cons_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pc4", cons_pc4[0], 32'h0000_0000);
        chk("wrap_instr0", cons_ins[0], mem_data(32'hFFFF_FFFC));
        chk("wrap_pc1", cons_pc[1], 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
